// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline slot with operand selection, load-use and hold stalls.
// Macro ID_EX_FWD_EN enables MEM/WB forwarding; undefined, decode stalls on every RAW hazard.
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1_addr,
  input  logic [4:0]      id_rs2_addr,
  input  logic [4:0]      id_rd_addr,
  input  logic [2:0]      id_op_type,
  input  logic            id_unsig,
  input  logic            id_a_sel,
  input  logic            id_b_sel,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_reg_write,
  input  logic [4:0]      mem_rd_addr,
  input  logic            mem_reg_write,
  input  logic [XLEN-1:0] mem_result,
  input  logic [4:0]      wb_rd_addr,
  input  logic            wb_reg_write,
  input  logic [XLEN-1:0] wb_result,
  input  logic            flush,
  input  logic            ex_hold,
  output logic [XLEN-1:0] a_alu,
  output logic [XLEN-1:0] b_alu,
  output logic [2:0]      op_type,
  output logic            unsig,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_store_data,
  output logic [4:0]      ex_rd_addr,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_reg_write,
  output logic            stall_id
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [4:0]      rd_addr;
    logic [2:0]      op_type;
    logic            unsig;
    logic            a_sel;
    logic            b_sel;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
  } slot_t;

  slot_t           slot_q, slot_d;
  logic            rs2_used, load_use, raw_hazard;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd;

  // rs2 matters for register-register ops and as store data
  assign rs2_used = ~id_b_sel | id_mem_write;

  assign load_use = slot_q.valid & slot_q.mem_read & (slot_q.rd_addr != 5'd0) & id_valid &
                    ((id_rs1_addr == slot_q.rd_addr) |
                     ((id_rs2_addr == slot_q.rd_addr) & rs2_used));

`ifdef ID_EX_FWD_EN
  assign raw_hazard = 1'b0;

  always_comb begin
    rs1_fwd = slot_q.rs1_data;
    rs2_fwd = slot_q.rs2_data;
    if (slot_q.rs1_addr != 5'd0 && mem_reg_write && mem_rd_addr == slot_q.rs1_addr)
      rs1_fwd = mem_result;
    else if (slot_q.rs1_addr != 5'd0 && wb_reg_write && wb_rd_addr == slot_q.rs1_addr)
      rs1_fwd = wb_result;
    if (slot_q.rs2_addr != 5'd0 && mem_reg_write && mem_rd_addr == slot_q.rs2_addr)
      rs2_fwd = mem_result;
    else if (slot_q.rs2_addr != 5'd0 && wb_reg_write && wb_rd_addr == slot_q.rs2_addr)
      rs2_fwd = wb_result;
  end
`else
  logic rs1_raw, rs2_raw, unused_fwd;

  // WB-stage producers are covered by the write-first register file
  assign rs1_raw = (id_rs1_addr != 5'd0) &
                   ((slot_q.valid & slot_q.reg_write & (slot_q.rd_addr == id_rs1_addr)) |
                    (mem_reg_write & (mem_rd_addr == id_rs1_addr)));
  assign rs2_raw = (id_rs2_addr != 5'd0) & rs2_used &
                   ((slot_q.valid & slot_q.reg_write & (slot_q.rd_addr == id_rs2_addr)) |
                    (mem_reg_write & (mem_rd_addr == id_rs2_addr)));
  assign raw_hazard = id_valid & (rs1_raw | rs2_raw);
  assign rs1_fwd    = slot_q.rs1_data;
  assign rs2_fwd    = slot_q.rs2_data;
  assign unused_fwd = ^{mem_result, wb_rd_addr, wb_reg_write, wb_result,
                        slot_q.rs1_addr, slot_q.rs2_addr};
`endif

  assign stall_id = (ex_hold & ~flush) | load_use | raw_hazard;

  always_comb begin
    slot_d = slot_q;
    if (flush || (!ex_hold && (load_use || raw_hazard || !id_valid))) begin
      slot_d.valid     = 1'b0;
      slot_d.mem_read  = 1'b0;
      slot_d.mem_write = 1'b0;
      slot_d.reg_write = 1'b0;
    end else if (!ex_hold) begin
      slot_d.valid     = 1'b1;
      slot_d.pc        = id_pc;
      slot_d.rs1_data  = id_rs1_data;
      slot_d.rs2_data  = id_rs2_data;
      slot_d.imm       = id_imm;
      slot_d.rs1_addr  = id_rs1_addr;
      slot_d.rs2_addr  = id_rs2_addr;
      slot_d.rd_addr   = id_rd_addr;
      slot_d.op_type   = id_op_type;
      slot_d.unsig     = id_unsig;
      slot_d.a_sel     = id_a_sel;
      slot_d.b_sel     = id_b_sel;
      slot_d.mem_read  = id_mem_read;
      slot_d.mem_write = id_mem_write;
      slot_d.reg_write = id_reg_write;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) slot_q <= '0;
    else     slot_q <= slot_d;
  end

  assign a_alu         = slot_q.a_sel ? slot_q.pc  : rs1_fwd;
  assign b_alu         = slot_q.b_sel ? slot_q.imm : rs2_fwd;
  assign ex_store_data = rs2_fwd;
  assign op_type       = slot_q.op_type;
  assign unsig         = slot_q.unsig;
  assign ex_valid      = slot_q.valid;
  assign ex_pc         = slot_q.pc;
  assign ex_rd_addr    = slot_q.rd_addr;
  assign ex_mem_read   = slot_q.mem_read;
  assign ex_mem_write  = slot_q.mem_write;
  assign ex_reg_write  = slot_q.reg_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard scenarios, then random traffic
// compared against an instruction-level reference model.
module tb_id_ex_stage;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, id_valid, id_unsig, id_a_sel, id_b_sel, id_mem_read, id_mem_write, id_reg_write;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm, mem_result, wb_result;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr, mem_rd_addr, wb_rd_addr;
  logic [2:0]  id_op_type, op_type;
  logic        mem_reg_write, wb_reg_write, flush, ex_hold;
  logic [31:0] a_alu, b_alu, ex_pc, ex_store_data;
  logic [4:0]  ex_rd_addr;
  logic        unsig, ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, stall_id;

  id_ex_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_op_type(id_op_type), .id_unsig(id_unsig), .id_a_sel(id_a_sel), .id_b_sel(id_b_sel),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_reg_write(id_reg_write),
    .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd_addr(wb_rd_addr), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .flush(flush), .ex_hold(ex_hold), .a_alu(a_alu), .b_alu(b_alu), .op_type(op_type),
    .unsig(unsig), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_store_data(ex_store_data),
    .ex_rd_addr(ex_rd_addr), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .stall_id(stall_id)
  );

  // The instruction the model believes sits in EX; known=0 means its data fields are don't-care
  typedef struct packed {
    logic        valid;
    logic        known;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1a, rs2a, rd;
    logic [2:0]  op;
    logic        unsig, asel, bsel, mr, mw, rw;
  } instr_t;

  instr_t ex;
  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Operand value as EX should see it: youngest pending writer first, then the slot copy
  function automatic logic [31:0] operand(input logic [4:0] a, input logic [31:0] regVal);
    logic [4:0]  wAddr [2];
    logic        wEn   [2];
    logic [31:0] wVal  [2];
    wAddr[0] = mem_rd_addr; wEn[0] = mem_reg_write; wVal[0] = mem_result;
    wAddr[1] = wb_rd_addr;  wEn[1] = wb_reg_write;  wVal[1] = wb_result;
`ifdef ID_EX_FWD_EN
    for (int i = 0; i < 2; i++)
      if (a != 5'd0 && wEn[i] && wAddr[i] == a) return wVal[i];
`endif
    return regVal;
  endfunction

  // Decode must wait if a needed source is not yet obtainable
  function automatic logic expStall();
    logic usesRs2;
    logic [4:0] src [2];
    logic need [2];
    usesRs2 = !id_b_sel || id_mem_write;
    src[0] = id_rs1_addr; need[0] = 1'b1;
    src[1] = id_rs2_addr; need[1] = usesRs2;
    if (ex_hold && !flush) return 1'b1;
    if (!id_valid) return 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (need[i] && ex.valid && ex.mr && ex.rd != 5'd0 && src[i] == ex.rd) return 1'b1;
`ifndef ID_EX_FWD_EN
      if (need[i] && src[i] != 5'd0 &&
          ((ex.valid && ex.rw && ex.rd == src[i]) || (mem_reg_write && mem_rd_addr == src[i])))
        return 1'b1;
`endif
    end
    return 1'b0;
  endfunction

  task automatic clearIn();
    rst = 0; id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0; id_op_type = 0; id_unsig = 0;
    id_a_sel = 0; id_b_sel = 0; id_mem_read = 0; id_mem_write = 0; id_reg_write = 0;
    mem_rd_addr = 0; mem_reg_write = 0; mem_result = 0;
    wb_rd_addr = 0; wb_reg_write = 0; wb_result = 0; flush = 0; ex_hold = 0;
  endtask

  task automatic setId(input logic [4:0] rs1a, input logic [4:0] rs2a, input logic [4:0] rd,
                       input logic mr, input logic rw, input logic [31:0] pc);
    id_valid = 1; id_rs1_addr = rs1a; id_rs2_addr = rs2a; id_rd_addr = rd;
    id_mem_read = mr; id_reg_write = rw; id_mem_write = 0; id_a_sel = 0; id_b_sel = 0;
    id_pc = pc; id_rs1_data = pc + 32'h11; id_rs2_data = pc + 32'h22; id_imm = pc + 32'h33;
    id_op_type = 3'd2; id_unsig = 1;
  endtask

  task automatic applyStimulus();
    rst           = ($urandom_range(0, 39) == 0);
    flush         = ($urandom_range(0, 7) == 0);
    ex_hold       = ($urandom_range(0, 4) == 0);
    id_valid      = ($urandom_range(0, 4) != 0);
    id_pc         = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
    id_rs1_addr   = 5'($urandom_range(0, 3));
    id_rs2_addr   = 5'($urandom_range(0, 3));
    id_rd_addr    = 5'($urandom_range(0, 3));
    id_op_type    = 3'($urandom_range(0, 7));
    id_unsig      = 1'($urandom_range(0, 1));
    id_a_sel      = 1'($urandom_range(0, 1));
    id_b_sel      = 1'($urandom_range(0, 1));
    id_mem_read   = ($urandom_range(0, 2) == 0);
    id_mem_write  = !id_mem_read && ($urandom_range(0, 3) == 0);
    id_reg_write  = 1'($urandom_range(0, 1));
    mem_rd_addr   = 5'($urandom_range(0, 3));
    mem_reg_write = 1'($urandom_range(0, 1));
    mem_result    = $urandom;
    wb_rd_addr    = 5'($urandom_range(0, 3));
    wb_reg_write  = 1'($urandom_range(0, 1));
    wb_result     = $urandom;
  endtask

  // Mid-cycle: compare every output against the model
  task automatic settle();
    #4;
    checkOutput("stall_id", stall_id, expStall());
    checkOutput("ex_valid", ex_valid, ex.valid);
    checkOutput("ex_mem_read", ex_mem_read, ex.mr);
    checkOutput("ex_mem_write", ex_mem_write, ex.mw);
    checkOutput("ex_reg_write", ex_reg_write, ex.rw);
    if (ex.known) begin
      checkOutput("ex_pc", ex_pc, ex.pc);
      checkOutput("ex_rd_addr", ex_rd_addr, ex.rd);
      checkOutput("op_type", op_type, ex.op);
      checkOutput("unsig", unsig, ex.unsig);
      checkOutput("a_alu", a_alu, ex.asel ? ex.pc : operand(ex.rs1a, ex.rs1d));
      checkOutput("b_alu", b_alu, ex.bsel ? ex.imm : operand(ex.rs2a, ex.rs2d));
      checkOutput("ex_store_data", ex_store_data, operand(ex.rs2a, ex.rs2d));
    end
  endtask

  // Decide what EX holds after the coming edge, then cross it
  task automatic advance();
    logic st;
    st = expStall();
    if (rst) begin
      ex = '0;
      ex.known = 1;
    end else if (flush || (!ex_hold && (st || !id_valid))) begin
      ex.valid = 0; ex.mr = 0; ex.mw = 0; ex.rw = 0; ex.known = 0;
    end else if (!ex_hold) begin
      ex.valid = 1; ex.known = 1; ex.pc = id_pc; ex.rs1d = id_rs1_data; ex.rs2d = id_rs2_data;
      ex.imm = id_imm; ex.rs1a = id_rs1_addr; ex.rs2a = id_rs2_addr; ex.rd = id_rd_addr;
      ex.op = id_op_type; ex.unsig = id_unsig; ex.asel = id_a_sel; ex.bsel = id_b_sel;
      ex.mr = id_mem_read; ex.mw = id_mem_write; ex.rw = id_reg_write;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    ex = '0;
    clearIn();
    rst = 1;
    advance();
    clearIn();
    settle();
    checkOutput("reset_a_alu", a_alu, 32'd0);
    checkOutput("reset_stall", stall_id, 1'b0);
    advance();

    $display("[TB] back-to-back dependent add");
    setId(0, 0, 1, 0, 1, 32'h40);
    settle(); advance();
    setId(1, 1, 2, 0, 1, 32'h44);
    settle();
`ifdef ID_EX_FWD_EN
    checkOutput("b2b_stall", stall_id, 1'b0);
`else
    checkOutput("b2b_stall_nofwd", stall_id, 1'b1);
`endif
    advance();
    clearIn();
    mem_rd_addr = 1; mem_reg_write = 1; mem_result = 5;
    settle();
`ifdef ID_EX_FWD_EN
    checkOutput("b2b_a_alu", a_alu, 32'd5);
    checkOutput("b2b_b_alu", b_alu, 32'd5);
`endif
    advance();

    $display("[TB] MEM over WB priority and x0");
    clearIn();
    settle(); advance();
    setId(3, 0, 5, 0, 1, 32'h100);
    settle(); advance();
    clearIn();
    mem_rd_addr = 3; mem_reg_write = 1; mem_result = 7;
    wb_rd_addr = 3; wb_reg_write = 1; wb_result = 9;
    settle();
`ifdef ID_EX_FWD_EN
    checkOutput("prio_a_alu", a_alu, 32'd7);
`else
    checkOutput("prio_a_alu_nofwd", a_alu, 32'h111);
`endif
    advance();
    clearIn();
    setId(0, 0, 6, 0, 1, 32'h200);
    settle(); advance();
    clearIn();
    mem_rd_addr = 0; mem_reg_write = 1; mem_result = 9;
    wb_rd_addr = 0; wb_reg_write = 1; wb_result = 9;
    settle();
    checkOutput("x0_a_alu", a_alu, 32'h211);
    advance();

    $display("[TB] load-use stall");
    clearIn();
    setId(0, 0, 4, 1, 1, 32'h300);
    settle(); advance();
    clearIn();
    setId(4, 0, 7, 0, 1, 32'h304);
    settle();
    checkOutput("lu_stall", stall_id, 1'b1);
    advance();
    settle();
    checkOutput("lu_bubble", ex_valid, 1'b0);
    checkOutput("lu_stall_release", stall_id, 1'b0);
    advance();
    settle();
    checkOutput("lu_loaded_valid", ex_valid, 1'b1);
    checkOutput("lu_loaded_rd", ex_rd_addr, 5'd7);
    advance();

    $display("[TB] flush over hold and stall");
    clearIn();
    setId(0, 0, 4, 1, 1, 32'h400);
    id_mem_write = 1;
    settle(); advance();
    clearIn();
    setId(4, 0, 8, 0, 1, 32'h404);
    ex_hold = 1; flush = 1;
    settle(); advance();
    clearIn();
    settle();
    checkOutput("flush_valid", ex_valid, 1'b0);
    checkOutput("flush_mr", ex_mem_read, 1'b0);
    checkOutput("flush_mw", ex_mem_write, 1'b0);
    checkOutput("flush_rw", ex_reg_write, 1'b0);
    advance();

    $display("[TB] three-cycle hold");
    setId(1, 2, 9, 0, 1, 32'h500);
    settle(); advance();
    for (int i = 0; i < 3; i++) begin
      ex_hold = 1; id_pc = $urandom; id_rs1_data = $urandom;
      settle();
      checkOutput("hold_stall", stall_id, 1'b1);
      checkOutput("hold_pc", ex_pc, 32'h500);
      advance();
    end
    clearIn();
    setId(0, 0, 10, 0, 1, 32'h600);
    settle(); advance();
    settle();
    checkOutput("hold_release_pc", ex_pc, 32'h600);
    advance();

    $display("[TB] reset during load-use stall");
    clearIn();
    setId(0, 0, 4, 1, 1, 32'h700);
    settle(); advance();
    setId(4, 0, 11, 0, 1, 32'h704);
    settle();
    checkOutput("rst_pre_stall", stall_id, 1'b1);
    rst = 1;
    advance();
    clearIn();
    settle();
    checkOutput("rst_valid", ex_valid, 1'b0);
    checkOutput("rst_a_alu", a_alu, 32'd0);
    checkOutput("rst_b_alu", b_alu, 32'd0);
    checkOutput("rst_pc", ex_pc, 32'd0);
    checkOutput("rst_rd", ex_rd_addr, 5'd0);
    checkOutput("rst_op", op_type, 3'd0);
    checkOutput("rst_stall", stall_id, 1'b0);
    advance();

    $display("[TB] random traffic");
    repeat (600) begin
      applyStimulus();
      settle();
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
